// File: rtl/fmap_writer.sv
// Feature-map sink: drops row-straddling windows, applies ReLU, shift and 8-bit
// saturation, and writes the surviving OW x OH map to a result RAM.
module fmap_writer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int DW     = 20,
    parameter int SHIFT  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sat_cnt
);

    localparam int OH = IMG_H - K + 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(OH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [ADDR_W-1:0]   addr;

    logic [DW-1:0]       relu_val;
    logic [DW-1:0]       shifted;
    logic                clip;
    logic [7:0]          pix;
    logic                keep;
    logic                last;

    // Negative results become zero before the shift, so a logical shift suffices.
    assign relu_val = in_data[DW-1] ? '0 : in_data;
    assign shifted  = relu_val >> SHIFT;
    assign clip     = shifted > DW'(255);
    assign pix      = clip ? 8'hFF : shifted[7:0];
    assign keep     = col >= COL_FIRST;
    assign last     = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat_cnt <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        col     <= '0;
                        row     <= '0;
                        addr    <= '0;
                        sat_cnt <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        // Columns left of K-1 belong to windows that wrap across rows.
                        if (keep) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= pix;
                            addr    <= addr + ADDR_W'(1);
                            if (clip && (sat_cnt != 16'hFFFF))
                                sat_cnt <= sat_cnt + 16'd1;
                        end
                        if (last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_writer.sv
// Directed bench for fmap_writer: full, gapped, corner-value, misuse, reset and
// back-to-back frames checked against a scoreboard of expected writes.
module tb_fmap_writer;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 5;
    localparam int DW     = 20;
    localparam int SHIFT  = 8;
    localparam int ADDR_W = 10;
    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int N_SAMP = IMG_W * OH;

    logic              clk;
    logic              rstn;
    logic              start;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic [15:0]       sat_cnt;

    fmap_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .sat_cnt(sat_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {sat_cnt, wr_addr, wr_data} per expected write
    logic [33:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int m_addr;
    int m_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (done) begin
                done_cnt++;
                check("done_with_wr_en", 32'(wr_en), 32'd1);
                check("done_addr", 32'(wr_addr), 32'(OW*OH-1));
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[17:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                    check("sat_cnt", 32'(sat_cnt), 32'(e[33:18]));
                end
            end
        end
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sample_val(input int idx, input bit corners);
        if (corners) begin
            case (idx)
                4: return 20'hFFFFF;
                5: return 20'h000FF;
                6: return 20'h00100;
                7: return 20'h0FFFF;
                8: return 20'h10000;
                9: return 20'h7FFFF;
                default: ;
            endcase
        end
        return DW'(idx << 8);
    endfunction

    task automatic push_expected(input logic [DW-1:0] d, input int idx);
        int r;
        logic [7:0] v;
        if (idx % IMG_W < K - 1) return;
        if ($signed(d) < 0) r = 0;
        else r = int'(d) >> SHIFT;
        if (r > 255) begin
            v = 8'hFF;
            if (m_sat < 16'hFFFF) m_sat++;
        end else begin
            v = 8'(r);
        end
        exp_q.push_back({16'(m_sat), 10'(m_addr), v});
        m_addr++;
    endtask

    task automatic run_frame(input bit corners, input bit gaps, input bit restart,
                             input int stop_after, input bit b2b);
        int n;
        if (b2b) check("b2b_in_done_cycle", 32'(done), 32'd1);
        start    = 1'b1;
        in_valid = b2b;      // ignored: start has not preceded it
        in_data  = 20'h12345;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        m_addr   = 0;
        m_sat    = 0;
        check("busy_armed", 32'(busy), 32'd1);
        n = (stop_after > 0) ? stop_after : N_SAMP;
        for (int idx = 0; idx < n; idx++) begin
            logic [DW-1:0] d;
            d        = sample_val(idx, corners);
            in_valid = 1'b1;
            in_data  = d;
            start    = restart && (idx == 100);
            push_expected(d, idx);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            if (gaps && (idx != n - 1) && ($urandom_range(0, 1) == 1)) begin
                repeat (2) begin
                    tick();
                    check("busy_in_gap", 32'(busy), 32'd1);
                end
            end
        end
        if (stop_after == 0) exp_done++;
    endtask

    task automatic finish_frame();
        tick();
        check("busy_after_frame", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("sat_cnt_final", 32'(sat_cnt), 32'(m_sat));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        check("sat_cnt_holds", 32'(sat_cnt), 32'(m_sat));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        // samples before start are ignored
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i << 8);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // contiguous frame: written indices above 255 all clip (576 - 216)
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0);
        finish_frame();
        check("sat_cnt_frame1", 32'(sat_cnt), 32'd360);

        run_frame(1'b0, 1'b1, 1'b0, 0, 1'b0);   // gapped
        finish_frame();

        run_frame(1'b1, 1'b0, 1'b0, 0, 1'b0);   // arithmetic corners
        finish_frame();
        check("sat_cnt_corners", 32'(sat_cnt), 32'd362);

        run_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);   // stray start mid-frame
        finish_frame();

        // reset mid-frame
        run_frame(1'b0, 1'b0, 1'b0, 300, 1'b0);
        tick();
        rstn = 1'b0;
        #1;
        check("midrst_wr_en",   32'(wr_en),   32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_done",    32'(done),    32'd0);
        check("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("midrst_queue",   32'(exp_q.size()), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0);
        finish_frame();

        // back-to-back frames
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b1);
        finish_frame();

        check("done_pulses", 32'(done_cnt), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
